// File: rtl/reorder_buffer_pkg.sv
// Shared types for the reorder buffer: instruction classes and the per-entry record.
package reorder_buffer_pkg;

    localparam int DEF_ROB_SIZE_BIT = 3;
    localparam int REG_ID_W         = 5;
    localparam int XLEN             = 32;

    typedef enum logic [1:0] {
        TYPE_REG    = 2'd0,
        TYPE_STORE  = 2'd1,
        TYPE_BRANCH = 2'd2
    } issue_type_e;

    typedef struct packed {
        logic                busy;
        logic                ready;
        issue_type_e         typ;
        logic [REG_ID_W-1:0] rd;
        logic [XLEN-1:0]     val;
        logic                pred_taken;
        logic                taken;
        logic [XLEN-1:0]     alt_pc;
    } rob_entry_t;

    // A retiring branch whose resolved direction disagrees with the prediction
    function automatic logic is_mispredict(input rob_entry_t e);
        return (e.typ == TYPE_BRANCH) && (e.taken != e.pred_taken);
    endfunction

endpackage

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates tags at issue, captures CDB results,
// retires in program order and flushes on a mispredicted branch.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_SIZE_BIT = DEF_ROB_SIZE_BIT
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    issue_valid,
    input  logic [1:0]              issue_type,
    input  logic [REG_ID_W-1:0]     issue_rd,
    input  logic                    issue_ready,
    input  logic [XLEN-1:0]         issue_val,
    input  logic                    issue_pred_taken,
    input  logic [XLEN-1:0]         issue_alt_pc,
    output logic                    rob_full,
    output logic [ROB_SIZE_BIT-1:0] rob_tail,
    output logic                    is_update_dep,
    output logic [REG_ID_W-1:0]     update_dep_id,
    output logic [ROB_SIZE_BIT-1:0] update_dep,
    input  logic                    cdb_valid,
    input  logic [ROB_SIZE_BIT-1:0] cdb_tag,
    input  logic [XLEN-1:0]         cdb_val,
    input  logic                    cdb_taken,
    input  logic [ROB_SIZE_BIT-1:0] qry1_tag,
    input  logic [ROB_SIZE_BIT-1:0] qry2_tag,
    output logic                    qry1_ready,
    output logic                    qry2_ready,
    output logic [XLEN-1:0]         qry1_val,
    output logic [XLEN-1:0]         qry2_val,
    output logic                    is_update_val,
    output logic [REG_ID_W-1:0]     update_val_id,
    output logic [ROB_SIZE_BIT-1:0] update_val_dep,
    output logic [XLEN-1:0]         update_val,
    output logic                    store_commit,
    output logic [ROB_SIZE_BIT-1:0] store_commit_tag,
    output logic                    rob_clear,
    output logic [XLEN-1:0]         clear_pc
);

    localparam int                  ROB_SIZE   = 1 << ROB_SIZE_BIT;
    localparam logic [ROB_SIZE_BIT:0] FULL_COUNT = (ROB_SIZE_BIT + 1)'(ROB_SIZE);

    rob_entry_t              r_rob [ROB_SIZE];
    logic [ROB_SIZE_BIT-1:0] r_head;
    logic [ROB_SIZE_BIT-1:0] r_tail;
    logic [ROB_SIZE_BIT:0]   r_count;

    logic                    w_full;
    logic                    w_accept;
    logic                    w_commit;
    rob_entry_t              w_head_ent;
    rob_entry_t              w_issue_ent;
    logic [ROB_SIZE_BIT:0]   w_count_next;

    // Occupancy, accept/commit qualification and the entry written at issue
    always_comb begin
        w_full       = (r_count == FULL_COUNT);
        w_head_ent   = r_rob[r_head];
        w_accept     = rdy_in & issue_valid & ~w_full & ~rob_clear;
        w_commit     = rdy_in & w_head_ent.busy & w_head_ent.ready & ~rob_clear;
        w_count_next = r_count + {{ROB_SIZE_BIT{1'b0}}, w_accept}
                               - {{ROB_SIZE_BIT{1'b0}}, w_commit};
        w_issue_ent  = '{busy:       1'b1,
                         ready:      issue_ready,
                         typ:        issue_type_e'(issue_type),
                         rd:         issue_rd,
                         val:        issue_val,
                         pred_taken: issue_pred_taken,
                         taken:      1'b0,
                         alt_pc:     issue_alt_pc};
        rob_full     = w_full;
        rob_tail     = r_tail;
    end

    // Same-cycle rename of the destination register to the allocated tag
    always_comb begin
        is_update_dep = w_accept & (issue_type_e'(issue_type) == TYPE_REG);
        update_dep_id = issue_rd;
        update_dep    = r_tail;
    end

    // Operand lookup with a bypass from the result being broadcast this cycle
    always_comb begin
        if (cdb_valid && (cdb_tag == qry1_tag)) begin
            qry1_ready = 1'b1;
            qry1_val   = cdb_val;
        end else begin
            qry1_ready = r_rob[qry1_tag].ready;
            qry1_val   = r_rob[qry1_tag].val;
        end
        if (cdb_valid && (cdb_tag == qry2_tag)) begin
            qry2_ready = 1'b1;
            qry2_val   = cdb_val;
        end else begin
            qry2_ready = r_rob[qry2_tag].ready;
            qry2_val   = r_rob[qry2_tag].val;
        end
    end

    // Entry storage, pointers and registered commit/flush outputs
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_head           <= '0;
            r_tail           <= '0;
            r_count          <= '0;
            for (int unsigned i = 0; i < ROB_SIZE; i++) begin
                r_rob[i[ROB_SIZE_BIT-1:0]].busy <= 1'b0;
            end
            is_update_val    <= 1'b0;
            update_val_id    <= '0;
            update_val_dep   <= '0;
            update_val       <= '0;
            store_commit     <= 1'b0;
            store_commit_tag <= '0;
            rob_clear        <= 1'b0;
            clear_pc         <= '0;
        end else if (rdy_in) begin
            if (rob_clear) begin
                r_head        <= '0;
                r_tail        <= '0;
                r_count       <= '0;
                for (int unsigned i = 0; i < ROB_SIZE; i++) begin
                    r_rob[i[ROB_SIZE_BIT-1:0]].busy <= 1'b0;
                end
                is_update_val <= 1'b0;
                store_commit  <= 1'b0;
                rob_clear     <= 1'b0;
            end else begin
                is_update_val <= 1'b0;
                store_commit  <= 1'b0;

                if (cdb_valid && r_rob[cdb_tag].busy) begin
                    r_rob[cdb_tag].val   <= cdb_val;
                    r_rob[cdb_tag].taken <= cdb_taken;
                    r_rob[cdb_tag].ready <= 1'b1;
                end

                if (w_commit) begin
                    r_rob[r_head].busy <= 1'b0;
                    r_head             <= r_head + ROB_SIZE_BIT'(1);
                    case (w_head_ent.typ)
                        TYPE_REG: begin
                            is_update_val  <= 1'b1;
                            update_val_id  <= w_head_ent.rd;
                            update_val_dep <= r_head;
                            update_val     <= w_head_ent.val;
                        end
                        TYPE_STORE: begin
                            store_commit     <= 1'b1;
                            store_commit_tag <= r_head;
                        end
                        default: begin
                            if (is_mispredict(w_head_ent)) begin
                                rob_clear <= 1'b1;
                                clear_pc  <= w_head_ent.alt_pc;
                            end
                        end
                    endcase
                end

                if (w_accept) begin
                    r_rob[r_tail] <= w_issue_ent;
                    r_tail        <= r_tail + ROB_SIZE_BIT'(1);
                end

                r_count <= w_count_next;
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus randomized
// traffic compared against a program-order queue model.
module tb_reorder_buffer;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in;
    logic        issue_valid;
    logic [1:0]  issue_type;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic [31:0] issue_val;
    logic        issue_pred_taken;
    logic [31:0] issue_alt_pc;
    logic        rob_full;
    logic [2:0]  rob_tail;
    logic        is_update_dep;
    logic [4:0]  update_dep_id;
    logic [2:0]  update_dep;
    logic        cdb_valid;
    logic [2:0]  cdb_tag;
    logic [31:0] cdb_val;
    logic        cdb_taken;
    logic [2:0]  qry1_tag, qry2_tag;
    logic        qry1_ready, qry2_ready;
    logic [31:0] qry1_val, qry2_val;
    logic        is_update_val;
    logic [4:0]  update_val_id;
    logic [2:0]  update_val_dep;
    logic [31:0] update_val;
    logic        store_commit;
    logic [2:0]  store_commit_tag;
    logic        rob_clear;
    logic [31:0] clear_pc;

    int checks   = 0;
    int failures = 0;

    reorder_buffer #(.ROB_SIZE_BIT(3)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
        .issue_ready(issue_ready), .issue_val(issue_val),
        .issue_pred_taken(issue_pred_taken), .issue_alt_pc(issue_alt_pc),
        .rob_full(rob_full), .rob_tail(rob_tail),
        .is_update_dep(is_update_dep), .update_dep_id(update_dep_id), .update_dep(update_dep),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val), .cdb_taken(cdb_taken),
        .qry1_tag(qry1_tag), .qry2_tag(qry2_tag),
        .qry1_ready(qry1_ready), .qry2_ready(qry2_ready),
        .qry1_val(qry1_val), .qry2_val(qry2_val),
        .is_update_val(is_update_val), .update_val_id(update_val_id),
        .update_val_dep(update_val_dep), .update_val(update_val),
        .store_commit(store_commit), .store_commit_tag(store_commit_tag),
        .rob_clear(rob_clear), .clear_pc(clear_pc)
    );

    always #5 clk_in = ~clk_in;

    // ---------------- reference model: in-flight instructions in program order
    typedef struct {
        logic [2:0]  tag;
        logic [1:0]  typ;
        logic [4:0]  rd;
        logic        rdy;
        logic [31:0] val;
        logic        pred;
        logic        taken;
        logic [31:0] alt;
    } ment_t;

    ment_t       mq[$];
    int          m_tail = 0;
    logic        exp_upd = 1'b0, exp_st = 1'b0, exp_clr = 1'b0;
    logic [4:0]  exp_upd_id = '0;
    logic [2:0]  exp_upd_dep = '0, exp_st_tag = '0;
    logic [31:0] exp_upd_val = '0, exp_clr_pc = '0;

    function automatic int find_tag(input logic [2:0] t);
        for (int i = 0; i < mq.size(); i++)
            if (mq[i].tag == t) return i;
        return -1;
    endfunction

    task automatic model_edge();
        ment_t e;
        logic  full;
        logic  n_upd, n_st, n_clr;
        int    k;
        if (rst_in) begin
            mq.delete(); m_tail = 0;
            exp_upd = 0; exp_upd_id = 0; exp_upd_dep = 0; exp_upd_val = 0;
            exp_st = 0; exp_st_tag = 0; exp_clr = 0; exp_clr_pc = 0;
            return;
        end
        if (!rdy_in) return;
        if (exp_clr) begin
            mq.delete(); m_tail = 0;
            exp_upd = 0; exp_st = 0; exp_clr = 0;
            return;
        end
        full  = (mq.size() == 8);
        n_upd = 0; n_st = 0; n_clr = 0;
        if (mq.size() > 0 && mq[0].rdy) begin
            e = mq.pop_front();
            if (e.typ == 2'd0) begin
                n_upd = 1; exp_upd_id = e.rd; exp_upd_dep = e.tag; exp_upd_val = e.val;
            end else if (e.typ == 2'd1) begin
                n_st = 1; exp_st_tag = e.tag;
            end else if (e.taken != e.pred) begin
                n_clr = 1; exp_clr_pc = e.alt;
            end
        end
        if (cdb_valid) begin
            k = find_tag(cdb_tag);
            if (k >= 0) begin
                mq[k].val = cdb_val; mq[k].taken = cdb_taken; mq[k].rdy = 1'b1;
            end
        end
        if (issue_valid && !full) begin
            e.tag = 3'(m_tail); e.typ = issue_type; e.rd = issue_rd; e.rdy = issue_ready;
            e.val = issue_val; e.pred = issue_pred_taken; e.taken = 1'b0; e.alt = issue_alt_pc;
            mq.push_back(e);
            m_tail = (m_tail + 1) % 8;
        end
        exp_upd = n_upd; exp_st = n_st; exp_clr = n_clr;
    endtask

    // ---------------- stimulus helpers (no checking)
    task automatic tick();
        @(posedge clk_in);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid = 0; issue_type = 0; issue_rd = 0; issue_ready = 0; issue_val = 0;
        issue_pred_taken = 0; issue_alt_pc = 0;
        cdb_valid = 0; cdb_tag = 0; cdb_val = 0; cdb_taken = 0;
        qry1_tag = 0; qry2_tag = 0;
    endtask

    task automatic set_issue(input logic [1:0] t, input logic [4:0] rd, input logic rdy,
                             input logic [31:0] val, input logic pred, input logic [31:0] alt);
        issue_valid = 1; issue_type = t; issue_rd = rd; issue_ready = rdy;
        issue_val = val; issue_pred_taken = pred; issue_alt_pc = alt;
    endtask

    task automatic set_cdb(input logic [2:0] t, input logic [31:0] v, input logic tk);
        cdb_valid = 1; cdb_tag = t; cdb_val = v; cdb_taken = tk;
    endtask

    task automatic do_reset();
        idle_inputs();
        rdy_in = 1; rst_in = 1;
        tick();
        rst_in = 0;
    endtask

    // ---------------- scenarios
    task automatic test_reset();
        idle_inputs();
        rdy_in = 1; rst_in = 1;
        tick(); tick();
        rst_in = 0;
        #1;
        checks++; if (rob_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", rob_full); end
        checks++; if (rob_tail !== 3'd0) begin failures++; $display("FAIL reset_tail got=%0d exp=0", rob_tail); end
        checks++; if (is_update_val !== 1'b0) begin failures++; $display("FAIL reset_upd got=%b exp=0", is_update_val); end
        checks++; if (store_commit !== 1'b0) begin failures++; $display("FAIL reset_st got=%b exp=0", store_commit); end
        checks++; if (rob_clear !== 1'b0) begin failures++; $display("FAIL reset_clr got=%b exp=0", rob_clear); end
        checks++; if (clear_pc !== 32'd0) begin failures++; $display("FAIL reset_pc got=%h exp=0", clear_pc); end
        checks++; if (update_val !== 32'd0) begin failures++; $display("FAIL reset_val got=%h exp=0", update_val); end
        checks++; if (is_update_dep !== 1'b0) begin failures++; $display("FAIL reset_dep got=%b exp=0", is_update_dep); end
    endtask

    task automatic test_in_order();
        logic [39:0] got[$];
        logic [39:0] expv[3];
        logic [2:0]  tags[3];
        logic [31:0] vals[3];
        expv[0] = {5'd5, 3'd0, 32'h00}; expv[1] = {5'd6, 3'd1, 32'h11}; expv[2] = {5'd7, 3'd2, 32'h22};
        tags[0] = 3'd2; tags[1] = 3'd0; tags[2] = 3'd1;
        vals[0] = 32'h22; vals[1] = 32'h00; vals[2] = 32'h11;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_issue(2'd0, 5'(5 + i), 1'b0, 32'h0, 1'b0, 32'h0);
            #1;
            checks++; if (is_update_dep !== 1'b1 || update_dep !== 3'(i) || update_dep_id !== 5'(5 + i)) begin
                failures++; $display("FAIL inorder_rename%0d got=%b/%0d/%0d exp=1/%0d/%0d", i, is_update_dep, update_dep, update_dep_id, i, 5 + i);
            end
            tick();
        end
        issue_valid = 0;
        for (int i = 0; i < 3; i++) begin
            set_cdb(tags[i], vals[i], 1'b0);
            tick();
            if (is_update_val) got.push_back({update_val_id, update_val_dep, update_val});
        end
        cdb_valid = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (is_update_val) got.push_back({update_val_id, update_val_dep, update_val});
        end
        checks++; if (got.size() != 3) begin failures++; $display("FAIL inorder_count got=%0d exp=3", got.size()); end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            checks++; if (got[i] !== expv[i]) begin failures++; $display("FAIL inorder_commit%0d got=%h exp=%h", i, got[i], expv[i]); end
        end
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_issue(2'd0, 5'(i + 1), 1'b0, 32'h0, 1'b0, 32'h0);
            tick();
        end
        issue_valid = 0; #1;
        checks++; if (rob_full !== 1'b1) begin failures++; $display("FAIL full_after8 got=%b exp=1", rob_full); end
        checks++; if (rob_tail !== 3'd0) begin failures++; $display("FAIL full_tail got=%0d exp=0", rob_tail); end
        set_issue(2'd0, 5'd20, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        checks++; if (is_update_dep !== 1'b0) begin failures++; $display("FAIL full_9th_rename got=%b exp=0", is_update_dep); end
        tick();
        checks++; if (rob_tail !== 3'd0) begin failures++; $display("FAIL full_9th_dropped got=%0d exp=0", rob_tail); end
        set_cdb(3'd0, 32'h55, 1'b0);
        tick();
        cdb_valid = 0; #1;
        checks++; if (is_update_dep !== 1'b0 || rob_full !== 1'b1) begin
            failures++; $display("FAIL full_commit_issue got=%b/%b exp=0/1", is_update_dep, rob_full);
        end
        tick();
        checks++; if (is_update_val !== 1'b1 || update_val_dep !== 3'd0 || update_val !== 32'h55) begin
            failures++; $display("FAIL full_commit got=%b/%0d/%h exp=1/0/00000055", is_update_val, update_val_dep, update_val);
        end
        checks++; if (rob_full !== 1'b0 || rob_tail !== 3'd0) begin
            failures++; $display("FAIL full_after_commit got=%b/%0d exp=0/0", rob_full, rob_tail);
        end
        #1;
        checks++; if (is_update_dep !== 1'b1 || update_dep !== 3'd0) begin
            failures++; $display("FAIL full_wrap_rename got=%b/%0d exp=1/0", is_update_dep, update_dep);
        end
        tick();
        issue_valid = 0; #1;
        checks++; if (rob_tail !== 3'd1 || rob_full !== 1'b1) begin
            failures++; $display("FAIL full_wrap got=%0d/%b exp=1/1", rob_tail, rob_full);
        end
    endtask

    task automatic test_mispredict();
        int         n_clr = 0, n_upd = 0;
        logic [31:0] pc_seen = '0;
        do_reset();
        set_issue(2'd2, 5'd0, 1'b0, 32'h0, 1'b0, 32'h100); tick();
        set_issue(2'd0, 5'd3, 1'b0, 32'h0, 1'b0, 32'h0);   tick();
        set_issue(2'd0, 5'd4, 1'b0, 32'h0, 1'b0, 32'h0);   tick();
        issue_valid = 0;
        for (int c = 0; c < 9; c++) begin
            if (c == 0)      set_cdb(3'd0, 32'h0, 1'b1);
            else if (c == 1) set_cdb(3'd1, 32'h1, 1'b0);
            else if (c == 2) set_cdb(3'd2, 32'h2, 1'b0);
            else             cdb_valid = 0;
            tick();
            if (rob_clear) begin n_clr++; pc_seen = clear_pc; end
            if (is_update_val) n_upd++;
        end
        checks++; if (n_clr != 1) begin failures++; $display("FAIL mispredict_clear_cycles got=%0d exp=1", n_clr); end
        checks++; if (pc_seen !== 32'h100) begin failures++; $display("FAIL mispredict_pc got=%h exp=00000100", pc_seen); end
        checks++; if (n_upd != 0) begin failures++; $display("FAIL mispredict_younger_commits got=%0d exp=0", n_upd); end
        checks++; if (rob_tail !== 3'd0 || rob_full !== 1'b0) begin
            failures++; $display("FAIL mispredict_empty got=%0d/%b exp=0/0", rob_tail, rob_full);
        end
    endtask

    task automatic test_query();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_issue(2'd0, 5'(i + 1), 1'b0, 32'h0, 1'b0, 32'h0);
            tick();
        end
        issue_valid = 0;
        qry1_tag = 3'd3; qry2_tag = 3'd2;
        set_cdb(3'd3, 32'hDEADBEEF, 1'b0);
        #1;
        checks++; if (qry1_ready !== 1'b1 || qry1_val !== 32'hDEADBEEF) begin
            failures++; $display("FAIL query_bypass got=%b/%h exp=1/deadbeef", qry1_ready, qry1_val);
        end
        checks++; if (qry2_ready !== 1'b0) begin failures++; $display("FAIL query_notready got=%b exp=0", qry2_ready); end
        tick();
        cdb_valid = 0; #1;
        checks++; if (qry1_ready !== 1'b1 || qry1_val !== 32'hDEADBEEF) begin
            failures++; $display("FAIL query_captured got=%b/%h exp=1/deadbeef", qry1_ready, qry1_val);
        end
    endtask

    task automatic test_stall_reset();
        int n_upd = 0;
        do_reset();
        set_issue(2'd0, 5'd9, 1'b1, 32'hAA, 1'b0, 32'h0);  tick();
        set_issue(2'd0, 5'd10, 1'b1, 32'hBB, 1'b0, 32'h0); tick();
        issue_valid = 0;
        checks++; if (is_update_val !== 1'b1 || update_val_id !== 5'd9) begin
            failures++; $display("FAIL stall_first got=%b/%0d exp=1/9", is_update_val, update_val_id);
        end
        rdy_in = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (is_update_val !== 1'b1 || update_val_id !== 5'd9 || update_val !== 32'hAA) begin
                failures++; $display("FAIL stall_hold%0d got=%b/%0d/%h exp=1/9/000000aa", c, is_update_val, update_val_id, update_val);
            end
        end
        rdy_in = 1;
        tick();
        checks++; if (is_update_val !== 1'b1 || update_val_id !== 5'd10 || update_val !== 32'hBB) begin
            failures++; $display("FAIL stall_next got=%b/%0d/%h exp=1/10/000000bb", is_update_val, update_val_id, update_val);
        end
        tick();
        checks++; if (is_update_val !== 1'b0) begin failures++; $display("FAIL stall_done got=%b exp=0", is_update_val); end

        for (int i = 0; i < 4; i++) begin
            set_issue(2'd0, 5'(i + 1), 1'b0, 32'h0, 1'b0, 32'h0);
            tick();
        end
        issue_valid = 0;
        rst_in = 1; tick(); rst_in = 0;
        checks++; if (rob_tail !== 3'd0 || rob_full !== 1'b0 || is_update_val !== 1'b0) begin
            failures++; $display("FAIL midreset got=%0d/%b/%b exp=0/0/0", rob_tail, rob_full, is_update_val);
        end
        for (int c = 0; c < 7; c++) begin
            if (c < 4) set_cdb(3'(c), 32'(c), 1'b0); else cdb_valid = 0;
            tick();
            if (is_update_val) n_upd++;
        end
        checks++; if (n_upd != 0) begin failures++; $display("FAIL midreset_commits got=%0d exp=0", n_upd); end
    endtask

    task automatic test_random();
        int          r, k;
        logic        efull, edep;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            idle_inputs();
            rdy_in = ($urandom_range(0, 9) != 0);
            if (rdy_in && $urandom_range(0, 2) != 0) begin
                r = $urandom_range(0, 19);
                set_issue(r < 12 ? 2'd0 : (r < 17 ? 2'd1 : 2'd2), 5'($urandom), 1'($urandom_range(0, 3) == 0),
                          $urandom, 1'($urandom), $urandom);
            end
            if ($urandom_range(0, 1) != 0) begin
                if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                    set_cdb(mq[$urandom_range(0, mq.size() - 1)].tag, $urandom, 1'($urandom));
                else
                    set_cdb(3'($urandom), $urandom, 1'($urandom));
            end
            qry1_tag = 3'($urandom); qry2_tag = 3'($urandom);
            #1;
            efull = (mq.size() == 8);
            edep  = issue_valid && rdy_in && !efull && !exp_clr && (issue_type == 2'd0);
            checks++; if (rob_full !== efull) begin failures++; $display("FAIL rnd_full c%0d got=%b exp=%b", cyc, rob_full, efull); end
            checks++; if (rob_tail !== 3'(m_tail)) begin failures++; $display("FAIL rnd_tail c%0d got=%0d exp=%0d", cyc, rob_tail, m_tail); end
            checks++; if (is_update_dep !== edep || (edep && (update_dep !== 3'(m_tail) || update_dep_id !== issue_rd))) begin
                failures++; $display("FAIL rnd_rename c%0d got=%b/%0d/%0d exp=%b/%0d/%0d", cyc, is_update_dep, update_dep, update_dep_id, edep, m_tail, issue_rd);
            end
            k = find_tag(qry1_tag);
            if (cdb_valid && cdb_tag == qry1_tag) begin
                checks++; if (qry1_ready !== 1'b1 || qry1_val !== cdb_val) begin
                    failures++; $display("FAIL rnd_qry1_bypass c%0d got=%b/%h exp=1/%h", cyc, qry1_ready, qry1_val, cdb_val);
                end
            end else if (k >= 0) begin
                checks++; if (qry1_ready !== mq[k].rdy || (mq[k].rdy && qry1_val !== mq[k].val)) begin
                    failures++; $display("FAIL rnd_qry1 c%0d got=%b/%h exp=%b/%h", cyc, qry1_ready, qry1_val, mq[k].rdy, mq[k].val);
                end
            end
            k = find_tag(qry2_tag);
            if (cdb_valid && cdb_tag == qry2_tag) begin
                checks++; if (qry2_ready !== 1'b1 || qry2_val !== cdb_val) begin
                    failures++; $display("FAIL rnd_qry2_bypass c%0d got=%b/%h exp=1/%h", cyc, qry2_ready, qry2_val, cdb_val);
                end
            end else if (k >= 0) begin
                checks++; if (qry2_ready !== mq[k].rdy || (mq[k].rdy && qry2_val !== mq[k].val)) begin
                    failures++; $display("FAIL rnd_qry2 c%0d got=%b/%h exp=%b/%h", cyc, qry2_ready, qry2_val, mq[k].rdy, mq[k].val);
                end
            end
            tick();
            checks++; if (is_update_val !== exp_upd || (exp_upd && {update_val_id, update_val_dep, update_val} !== {exp_upd_id, exp_upd_dep, exp_upd_val})) begin
                failures++; $display("FAIL rnd_commit c%0d got=%b/%0d/%0d/%h exp=%b/%0d/%0d/%h", cyc, is_update_val, update_val_id, update_val_dep, update_val, exp_upd, exp_upd_id, exp_upd_dep, exp_upd_val);
            end
            checks++; if (store_commit !== exp_st || (exp_st && store_commit_tag !== exp_st_tag)) begin
                failures++; $display("FAIL rnd_store c%0d got=%b/%0d exp=%b/%0d", cyc, store_commit, store_commit_tag, exp_st, exp_st_tag);
            end
            checks++; if (rob_clear !== exp_clr || (exp_clr && clear_pc !== exp_clr_pc)) begin
                failures++; $display("FAIL rnd_clear c%0d got=%b/%h exp=%b/%h", cyc, rob_clear, clear_pc, exp_clr, exp_clr_pc);
            end
        end
        rdy_in = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in = 1; rdy_in = 1;
        idle_inputs();
        test_reset();
        test_in_order();
        test_full_wrap();
        test_mispredict();
        test_query();
        test_stall_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
